music_seq: RTL and testbench

Score sequencer that sits directly upstream of the buzzer tone generator. It walks a synchronous song ROM and decodes each entry (note code plus duration) into a 17-bit half-period-pair count, `period`, in system clocks. It holds each note for a whole number of beats and supports play/pause from a single push-button. The downstream tone generator toggles the buzzer at `period` and treats `period == 0` as silence.

---
 rtl/music_seq.sv | 193 +++++++++++++++++++
 tb/tb_music_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_seq.sv
// music_seq: score sequencer feeding the buzzer tone generator.
// Walks a synchronous song ROM. Each entry holds a note code and a beat
// count. The block turns the note code into a tone half-period count and
// holds it for the note's beats. A single push-button toggles play/pause.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_play   raw push-button, active-low, asynchronous to clk
//   rom_addr   song ROM address
//   rom_data   ROM word, valid 1 clock after rom_addr
//              [4:0] note code, [7:5] beats-1
//   period     tone period in clocks, 0 = silence
//   period_vld 1-cycle pulse when period takes a new note value
//   playing    high while fetching, loading or holding a note
//
// Build option: define MUSIC_SEQ_DEBOUNCE_EN to insert a DEB_CYC-clock
// debounce filter after the key synchronizer.
module music_seq #(
  parameter int BEAT_CYC  = 12_500_000,
  parameter int DEB_CYC   = 1_000_000,
  parameter int LAST_ADDR = 255,
  parameter int LOOP      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_play,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic [16:0] period,
  output logic        period_vld,
  output logic        playing
);

  localparam int BW = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYC - 1);
  localparam logic [7:0]    ADDR_LAST = 8'(LAST_ADDR);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, HOLD, PAUSE} state_t;

  state_t          state;
  logic            key_s1, key_s2, key_lvl, key_prev, press;
  logic [BW-1:0]   beat_cnt;
  logic [3:0]      beats_left;
  logic [16:0]     note_per;
  logic            beat_wrap, last_beat;

  // Key synchronizer; idles released (high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_play;
      key_s2 <= key_s1;
    end
  end

`ifdef MUSIC_SEQ_DEBOUNCE_EN
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic [DW-1:0] deb_cnt;
  logic          deb_lvl;

  // The level only moves after DEB_CYC consecutive clocks of disagreement;
  // any return to the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b1;
    end else if (key_s2 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      deb_lvl <= key_s2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign key_lvl = deb_lvl;
`else
  assign key_lvl = key_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_prev <= 1'b1;
    else        key_prev <= key_lvl;
  end

  // One-cycle press event on the falling edge of the key level.
  assign press = key_prev & ~key_lvl;

  function automatic logic [16:0] note_period(input logic [4:0] code);
    case (code)
      5'd1:    return 17'd95602;
      5'd2:    return 17'd85178;
      5'd3:    return 17'd75872;
      5'd4:    return 17'd71633;
      5'd5:    return 17'd63775;
      5'd6:    return 17'd56818;
      5'd7:    return 17'd50607;
      5'd8:    return 17'd47801;
      5'd9:    return 17'd42553;
      5'd10:   return 17'd37936;
      5'd11:   return 17'd35791;
      5'd12:   return 17'd31888;
      5'd13:   return 17'd28409;
      5'd14:   return 17'd25303;
      5'd15:   return 17'd127551;
      5'd16:   return 17'd113636;
      5'd17:   return 17'd101215;
      default: return '0;
    endcase
  endfunction

  assign beat_wrap = (beat_cnt == BEAT_LAST);
  assign last_beat = (beats_left == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      playing    <= 1'b0;
      beat_cnt   <= '0;
      beats_left <= '0;
      note_per   <= '0;
    end else begin
      period_vld <= 1'b0;
      case (state)
        IDLE: begin
          rom_addr <= '0;
          period   <= '0;
          if (press) begin
            state   <= FETCH;
            playing <= 1'b1;
          end
        end

        FETCH: state <= LOAD;

        LOAD: begin
          note_per   <= note_period(rom_data[4:0]);
          period     <= note_period(rom_data[4:0]);
          period_vld <= 1'b1;
          beats_left <= {1'b0, rom_data[7:5]} + 4'd1;
          beat_cnt   <= '0;
          state      <= HOLD;
        end

        HOLD: begin
          // The press cycle still counts as a held cycle. On the last-beat
          // wrap the press suppresses the advance and leaves one beat
          // remaining, so resuming replays a full beat of the same note.
          beat_cnt <= beat_wrap ? '0 : beat_cnt + 1'b1;
          if (beat_wrap && !last_beat) beats_left <= beats_left - 4'd1;
          if (press) begin
            state   <= PAUSE;
            period  <= '0;
            playing <= 1'b0;
          end else if (beat_wrap && last_beat) begin
            if (rom_addr != ADDR_LAST) begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
            end else if (LOOP != 0) begin
              rom_addr <= '0;
              state    <= FETCH;
            end else begin
              rom_addr <= '0;
              period   <= '0;
              playing  <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        PAUSE: begin
          if (press) begin
            period  <= note_per;
            playing <= 1'b1;
            state   <= HOLD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_seq.sv
// Testbench for music_seq with a 4-clock beat and a 4-entry song.
// Two instances share clock, reset, key and ROM contents: dut loops the
// song, dut0 stops at the end of it.
module tb_music_seq;

  localparam int unsigned BEAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_play = 1'b1;
  logic [7:0]  addr1, addr0, rd1, rd0;
  logic [16:0] per1, per0;
  logic        vld1, vld0, ply1, ply0;

  logic [7:0]  rom [0:255];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  int unsigned tbl [0:17] = '{0, 95602, 85178, 75872, 71633, 63775, 56818, 50607,
                              47801, 42553, 37936, 35791, 31888, 28409, 25303,
                              127551, 113636, 101215};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd1 <= rom[addr1];
    rd0 <= rom[addr0];
  end

  music_seq #(.BEAT_CYC(4), .DEB_CYC(8), .LAST_ADDR(3), .LOOP(1)) dut (
    .clk(clk), .rst_n(rst_n), .key_play(key_play), .rom_addr(addr1),
    .rom_data(rd1), .period(per1), .period_vld(vld1), .playing(ply1));

  music_seq #(.BEAT_CYC(4), .DEB_CYC(8), .LAST_ADDR(3), .LOOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_play(key_play), .rom_addr(addr0),
    .rom_data(rd0), .period(per0), .period_vld(vld0), .playing(ply0));

  function automatic logic [16:0] ref_period(input logic [7:0] w);
    int unsigned c;
    c = int'(w[4:0]);
    return (c < 18) ? 17'(tbl[c]) : 17'd0;
  endfunction

  function automatic int unsigned ref_beats(input logic [7:0] w);
    return 32'(w[7:5]) + 1;
  endfunction

  task automatic load_song(input logic [7:0] a, b, c, d);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_play = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Call at a negedge: key goes low now, released three clocks later.
  task automatic press_key();
    key_play = 1'b0;
    fork
      begin
        repeat (3) @(negedge clk);
        key_play = 1'b1;
      end
    join_none
  endtask

  task automatic wait_vld(input int unsigned limit, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (vld1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit quiet;
    rst_n = 1'b0;
    key_play = 1'b1;
    load_song(8'h23, 8'h08, 8'h00, 8'h1F);
    @(negedge clk);
    n_cmp++;
    if ({addr1, per1, vld1, ply1, addr0, per0, vld0, ply0} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got addr=%0d per=%0d vld=%0b ply=%0b, want all 0",
               addr1, per1, vld1, ply1);
    end
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (vld1 || ply1 || per1 != 0 || addr1 != 0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_bad++;
      $display("FAIL reset_idle: got activity without press, want none");
    end
  endtask

  task automatic test_start();
    int unsigned tp, gap, idx;
    bit ok;
    do_reset();
    load_song(8'h23, 8'h08, 8'h00, 8'h1F);
    tp = cyc;
    press_key();
    wait_vld(20, ok);
    n_cmp++;
    if (!ok || cyc - tp != 5) begin
      n_bad++;
      $display("FAIL start_latency: got %0d clocks (seen=%0b), want 5", cyc - tp, ok);
    end
    n_cmp++;
    if (per1 !== ref_period(rom[0]) || addr1 !== 8'd0) begin
      n_bad++;
      $display("FAIL start_note: got per=%0d addr=%0d, want per=%0d addr=0",
               per1, addr1, ref_period(rom[0]));
    end
    tp = cyc;
    for (int k = 1; k <= 4; k++) begin
      idx = k % 4;
      gap = ref_beats(rom[(k - 1) % 4]) * BEAT + 2;
      wait_vld(gap + 5, ok);
      n_cmp++;
      if (!ok || cyc - tp != gap) begin
        n_bad++;
        $display("FAIL start_gap k=%0d: got %0d clocks, want %0d", k, cyc - tp, gap);
      end
      n_cmp++;
      if (per1 !== ref_period(rom[idx]) || addr1 !== 8'(idx)) begin
        n_bad++;
        $display("FAIL start_seq k=%0d: got per=%0d addr=%0d, want per=%0d addr=%0d",
                 k, per1, addr1, ref_period(rom[idx]), idx);
      end
      tp = cyc;
    end
    // Two clocks after the last wrap the non-looping copy must be idle.
    n_cmp++;
    if (ply0 !== 1'b0 || per0 !== '0 || addr0 !== '0) begin
      n_bad++;
      $display("FAIL end_no_loop: got ply=%0b per=%0d addr=%0d, want 0 0 0", ply0, per0, addr0);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      logic [7:0]  w [4];
      logic [16:0] cur;
      int unsigned tp, gap;
      bit ok, steady;
      do_reset();
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      load_song(w[0], w[1], w[2], w[3]);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      tp = cyc;
      press_key();
      gap = 5;
      cur = '0;
      for (int k = 0; k < 6; k++) begin
        steady = 1'b1;
        ok = 1'b0;
        for (int unsigned c = 0; c < gap + 3; c++) begin
          @(negedge clk);
          if (vld1) begin
            ok = 1'b1;
            break;
          end
          if (k > 0 && per1 !== cur) steady = 1'b0;
        end
        n_cmp++;
        if (!ok || cyc - tp != gap) begin
          n_bad++;
          $display("FAIL rand_gap r=%0d k=%0d: got %0d clocks, want %0d", r, k, cyc - tp, gap);
        end
        n_cmp++;
        if (per1 !== ref_period(w[k % 4]) || addr1 !== 8'(k % 4)) begin
          n_bad++;
          $display("FAIL rand_note r=%0d k=%0d: got per=%0d addr=%0d, want per=%0d addr=%0d",
                   r, k, per1, addr1, ref_period(w[k % 4]), k % 4);
        end
        if (k > 0) begin
          n_cmp++;
          if (!steady) begin
            n_bad++;
            $display("FAIL rand_hold r=%0d k=%0d: period changed mid-note, want steady %0d",
                     r, k, cur);
          end
        end
        cur = ref_period(w[k % 4]);
        tp = cyc;
        gap = ref_beats(w[k % 4]) * BEAT + 2;
      end
    end
  endtask

  task automatic test_pause();
    int unsigned tr, remaining;
    bit ok, frozen;
    do_reset();
    load_song(8'h64, 8'h0B, 8'h00, 8'h00);
    press_key();
    wait_vld(20, ok);
    // Key falls now, so the press lands on the third held cycle (counter 2).
    press_key();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || per1 !== '0 || ply1 !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_enter: got per=%0d ply=%0b, want 0 0", per1, ply1);
    end
    frozen = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (per1 != 0 || vld1 || ply1 || addr1 != 0) frozen = 1'b0;
    end
    n_cmp++;
    if (!frozen) begin
      n_bad++;
      $display("FAIL pause_hold: got activity during pause, want silent and frozen");
    end
    press_key();
    ok = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (vld1) ok = 1'b1;
    end
    n_cmp++;
    if (per1 !== ref_period(8'h64) || ok || ply1 !== 1'b1) begin
      n_bad++;
      $display("FAIL pause_resume: got per=%0d vld_seen=%0b ply=%0b, want per=%0d no vld ply=1",
               per1, ok, ply1, ref_period(8'h64));
    end
    tr = cyc;
    remaining = ref_beats(8'h64) * BEAT - 3;
    wait_vld(40, ok);
    n_cmp++;
    if (!ok || cyc - tr != remaining + 2) begin
      n_bad++;
      $display("FAIL pause_tail: got %0d clocks, want %0d", cyc - tr, remaining + 2);
    end
    n_cmp++;
    if (per1 !== ref_period(8'h0B) || addr1 !== 8'd1) begin
      n_bad++;
      $display("FAIL pause_next: got per=%0d addr=%0d, want per=%0d addr=1",
               per1, addr1, ref_period(8'h0B));
    end
  endtask

  task automatic test_collision();
    int unsigned tr;
    bit ok, quiet;
    do_reset();
    load_song(8'h24, 8'h08, 8'h00, 8'h00);
    press_key();
    wait_vld(20, ok);
    // Press lands on the eighth (final) held cycle: the last-beat wrap.
    repeat (5) @(negedge clk);
    press_key();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || per1 !== '0 || addr1 !== 8'd0 || ply1 !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_pause: got per=%0d addr=%0d ply=%0b, want 0 0 0", per1, addr1, ply1);
    end
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (vld1 || addr1 != 0) quiet = 1'b0;
    end
    press_key();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!quiet || per1 !== ref_period(8'h24)) begin
      n_bad++;
      $display("FAIL collide_resume: got per=%0d quiet=%0b, want per=%0d quiet=1",
               per1, quiet, ref_period(8'h24));
    end
    tr = cyc;
    wait_vld(20, ok);
    n_cmp++;
    if (!ok || cyc - tr != BEAT + 2 || per1 !== ref_period(8'h08) || addr1 !== 8'd1) begin
      n_bad++;
      $display("FAIL collide_extra_beat: got %0d clocks per=%0d addr=%0d, want %0d clocks per=%0d addr=1",
               cyc - tr, per1, addr1, BEAT + 2, ref_period(8'h08));
    end
  endtask

  task automatic test_bounce();
    logic [16:0] p [0:28];
    logic        pl [0:28];
    int          nvld;
    do_reset();
    load_song(8'h64, 8'h00, 8'h00, 8'h00);
    // Low 5, high 3, low 20: without a debounce filter both falls are presses.
    key_play = 1'b0;
    nvld = 0;
    for (int o = 1; o <= 28; o++) begin
      @(negedge clk);
      p[o] = per1;
      pl[o] = ply1;
      if (vld1) nvld++;
      if (o == 5) key_play = 1'b1;
      if (o == 8) key_play = 1'b0;
    end
    key_play = 1'b1;
    n_cmp++;
    if (p[5] !== ref_period(8'h64) || p[10] !== ref_period(8'h64) || nvld != 1) begin
      n_bad++;
      $display("FAIL bounce_first: got per5=%0d per10=%0d vlds=%0d, want %0d %0d 1",
               p[5], p[10], nvld, ref_period(8'h64), ref_period(8'h64));
    end
    n_cmp++;
    if (p[11] !== '0 || pl[11] !== 1'b0 || p[28] !== '0) begin
      n_bad++;
      $display("FAIL bounce_second: got per11=%0d ply11=%0b per28=%0d, want 0 0 0",
               p[11], pl[11], p[28]);
    end
  endtask

  task automatic test_async_reset();
    int unsigned tp;
    bit ok, quiet;
    do_reset();
    load_song(8'h23, 8'h08, 8'h00, 8'h1F);
    press_key();
    wait_vld(20, ok);
    wait_vld(20, ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!ok || addr1 !== 8'd1 || per1 !== ref_period(8'h08)) begin
      n_bad++;
      $display("FAIL arst_pre: got addr=%0d per=%0d, want addr=1 per=%0d",
               addr1, per1, ref_period(8'h08));
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({addr1, per1, vld1, ply1, addr0, per0, vld0, ply0} !== '0) begin
      n_bad++;
      $display("FAIL arst_immediate: got addr=%0d per=%0d ply=%0b, want all 0", addr1, per1, ply1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (vld1 || ply1 || per1 != 0 || addr1 != 0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_bad++;
      $display("FAIL arst_idle: got activity after reset, want none");
    end
    tp = cyc;
    press_key();
    wait_vld(20, ok);
    n_cmp++;
    if (!ok || cyc - tp != 5 || per1 !== ref_period(8'h23)) begin
      n_bad++;
      $display("FAIL arst_restart: got %0d clocks per=%0d, want 5 clocks per=%0d",
               cyc - tp, per1, ref_period(8'h23));
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_random();
    test_pause();
    test_collision();
    test_bounce();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
